// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared pipeline defaults, bubble encoding and stage-state enum
//
// Purpose : constants and types shared by pipeline stage registers.
// Contents: PIPE_PC_W / PIPE_DATA_W default field widths,
//           PIPE_BUBBLE_DATA payload used for empty or killed slots,
//           stage_state_e occupancy-encoded stage state (EMPTY/ONE/TWO).
package pipe_stage_reg_pkg;

  localparam int PIPE_PC_W   = 32;
  localparam int PIPE_DATA_W = 32;

  localparam logic [31:0] PIPE_BUBBLE_DATA = 32'h0000_0000;

  // Encoding equals the number of held entries so it can be exported
  // directly as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating up-counter for performance monitoring
//
// Purpose : counts cycles with inc=1, sticks at all-ones instead of wrapping.
// Ports   : clk   in  clock, rising edge
//           clear in  synchronous clear (highest priority)
//           inc   in  count this cycle
//           count out current count, CNT_W bits
module pipe_stage_reg_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - PC + payload pipeline stage register with handshake, freeze and flush
//
// Purpose : carries one PC/payload entry between two pipeline stages with
//           valid/ready backpressure. SKID=1 adds a second (skid) entry so
//           in_ready depends only on local state; SKID=0 keeps one entry and
//           lets out_ready pass combinationally to in_ready.
// Ports   : clk, rst            clock, synchronous active-high reset
//           freeze              global hold (no accept, no emit, state held)
//           flush               kill held entries, drop this cycle's input
//           in_valid/in_ready   upstream handshake, in_pc/in_data payload
//           out_valid/out_ready downstream handshake, out_pc/out_data main entry
//           occupancy           entries held (0..2)
//           freeze_cnt          saturating count of freeze cycles
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               PC_W        = PIPE_PC_W,
  parameter int               DATA_W      = PIPE_DATA_W,
  parameter int               SKID        = 1,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(PIPE_BUBBLE_DATA),
  parameter int               CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  freeze_cnt
);

  stage_state_e      state, state_n;
  logic [PC_W-1:0]   main_pc, main_pc_n, skid_pc, skid_pc_n;
  logic [DATA_W-1:0] main_data, main_data_n, skid_data, skid_data_n;
  logic              main_valid;
  logic              can_take;
  logic              accept, emit;

  assign main_valid = (state != ST_EMPTY);

  // Skid mode only looks at its own state; single-entry mode may refill in
  // the same cycle the downstream drains it.
  assign can_take = (SKID != 0) ? (state != ST_TWO)
                                : ((state == ST_EMPTY) | out_ready);

  assign in_ready  = can_take & ~freeze & ~flush;
  assign out_valid = main_valid & ~freeze & ~flush;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  assign out_pc    = main_pc;
  assign out_data  = main_data;
  assign occupancy = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_pc   <= '0;
      main_data <= BUBBLE_DATA;
      skid_pc   <= '0;
      skid_data <= BUBBLE_DATA;
    end else begin
      state     <= state_n;
      main_pc   <= main_pc_n;
      main_data <= main_data_n;
      skid_pc   <= skid_pc_n;
      skid_data <= skid_data_n;
    end
  end

  // Freeze needs no branch of its own: it forces accept and emit low, so
  // every arm below falls through to hold.
  always_comb begin
    state_n     = state;
    main_pc_n   = main_pc;
    main_data_n = main_data;
    skid_pc_n   = skid_pc;
    skid_data_n = skid_data;
    if (flush) begin
      state_n     = ST_EMPTY;
      main_pc_n   = '0;
      main_data_n = BUBBLE_DATA;
      skid_pc_n   = '0;
      skid_data_n = BUBBLE_DATA;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_n     = ST_ONE;
            main_pc_n   = in_pc;
            main_data_n = in_data;
          end
        end
        ST_ONE: begin
          if (accept && !emit) begin
            // Only reachable with SKID=1: single-entry mode accepts when
            // full only while emitting.
            state_n     = ST_TWO;
            skid_pc_n   = in_pc;
            skid_data_n = in_data;
          end else if (accept && emit) begin
            main_pc_n   = in_pc;
            main_data_n = in_data;
          end else if (emit) begin
            state_n     = ST_EMPTY;
            main_pc_n   = '0;
            main_data_n = BUBBLE_DATA;
          end
        end
        ST_TWO: begin
          if (emit) begin
            state_n     = ST_ONE;
            main_pc_n   = skid_pc;
            main_data_n = skid_data;
            skid_pc_n   = '0;
            skid_data_n = BUBBLE_DATA;
          end
        end
        default: begin
          state_n = ST_EMPTY;
        end
      endcase
    end
  end

  pipe_stage_reg_sat_counter #(
    .CNT_W (CNT_W)
  ) u_freeze_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (freeze),
    .count (freeze_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench for pipe_stage_reg (skid and single-entry)
module tb_pipe_stage_reg;

  localparam logic [31:0] BUB = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_data;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_out_data;
  logic [1:0]  s_occ;
  logic [3:0]  s_fcnt;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_pc, n_out_data;
  logic [1:0]  n_occ;
  logic [15:0] n_fcnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .PC_W(32), .DATA_W(32), .SKID(1), .BUBBLE_DATA(BUB), .CNT_W(4)
  ) dut_skid (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_data(s_out_data),
    .occupancy(s_occ), .freeze_cnt(s_fcnt)
  );

  pipe_stage_reg #(
    .PC_W(32), .DATA_W(32), .SKID(0), .BUBBLE_DATA(BUB), .CNT_W(16)
  ) dut_single (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc), .out_data(n_out_data),
    .occupancy(n_occ), .freeze_cnt(n_fcnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: each stage is a FIFO of {pc,data} with a capacity limit.
  logic [63:0] qs[$];
  logic [63:0] qn[$];
  int          cnt_s = 0;
  int          cnt_n = 0;
  logic [31:0] pc_ctr = 32'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic fz, input logic fl,
                       input logic iv, input logic ordy);
    logic        rdy_s, rdy_n, ov_s, ov_n;
    logic [63:0] hd_s, hd_n;
    rst = r; freeze = fz; flush = fl; in_valid = iv; out_ready = ordy;
    in_pc = pc_ctr; in_data = $urandom;
    pc_ctr = pc_ctr + 32'h4;
    @(negedge clk);

    rdy_s = !fz && !fl && (qs.size() < 2);
    rdy_n = !fz && !fl && ((qn.size() == 0) || ordy);
    ov_s  = !fz && !fl && (qs.size() > 0);
    ov_n  = !fz && !fl && (qn.size() > 0);
    hd_s  = (qs.size() > 0) ? qs[0] : {32'h0, BUB};
    hd_n  = (qn.size() > 0) ? qn[0] : {32'h0, BUB};

    chk("skid.in_ready",   s_in_ready,  rdy_s);
    chk("skid.out_valid",  s_out_valid, ov_s);
    chk("skid.out_pc",     s_out_pc,    hd_s[63:32]);
    chk("skid.out_data",   s_out_data,  hd_s[31:0]);
    chk("skid.occupancy",  s_occ,       qs.size());
    chk("skid.freeze_cnt", s_fcnt,      cnt_s);
    chk("one.in_ready",    n_in_ready,  rdy_n);
    chk("one.out_valid",   n_out_valid, ov_n);
    chk("one.out_pc",      n_out_pc,    hd_n[63:32]);
    chk("one.out_data",    n_out_data,  hd_n[31:0]);
    chk("one.occupancy",   n_occ,       qn.size());
    chk("one.freeze_cnt",  n_fcnt,      cnt_n);

    if (r) begin
      qs.delete(); qn.delete(); cnt_s = 0; cnt_n = 0;
    end else begin
      if (fz) begin
        if (cnt_s < 15)    cnt_s++;
        if (cnt_n < 65535) cnt_n++;
      end
      if (fl) begin
        qs.delete(); qn.delete();
      end else if (!fz) begin
        if (ov_s && ordy) void'(qs.pop_front());
        if (ov_n && ordy) void'(qn.pop_front());
        if (iv && rdy_s) qs.push_back({in_pc, in_data});
        if (iv && rdy_n) qn.push_back({in_pc, in_data});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with input offered
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    // streaming
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 1);
    // backpressure, then drain
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    // freeze with one entry held, then long freeze to saturate the 4-bit counter
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++)  cycle(0, 1, 0, 1, 1);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 1, 1);
    for (int i = 0; i < 2; i++)  cycle(0, 0, 0, 0, 1);
    // fill, then flush together with freeze while input is offered
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    // out_ready toggling with continuous input
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register carrying a PC plus a payload between two pipeline stages, with valid/ready handshake, freeze (global stall) and flush (kill/bubble). It replaces fixed per-stage PC/Instruction registers and adds backpressure, with an optional 2-entry skid buffer that breaks the ready path. It also exposes occupancy and a saturating freeze-cycle counter for performance monitoring.

Parameters:
PC_W, 32, width of the PC field
DATA_W, 32, width of the payload field (instruction or decoded bundle)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
BUBBLE_DATA, 0, payload value driven and held when the stage is empty or flushed (NOP encoding)
CNT_W, 16, width of the freeze-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  global hold: no accept, no emit, state held
flush  in  1  kill all held entries and drop the input this cycle
in_valid  in  1  upstream has an entry
in_ready  out  1  stage accepts this cycle
in_pc  in  PC_W  upstream PC
in_data  in  DATA_W  upstream payload
out_valid  out  1  stage presents an entry
out_ready  in  1  downstream accepts
out_pc  out  PC_W  held PC (main entry)
out_data  out  DATA_W  held payload (main entry)
occupancy  out  2  entries held: 0..2 (0..1 when SKID=0)
freeze_cnt  out  CNT_W  saturating count of cycles with freeze=1

Behaviour:
- Reset is synchronous and active-high (rst sampled on rising clk). Outputs at/after reset: out_valid=0, out_pc=0, out_data=BUBBLE_DATA, occupancy=0, freeze_cnt=0; in_ready=1 unless freeze or flush is high.
- Priority per edge: rst > flush > freeze > normal transfer.
- accept = in_valid & in_ready; emit = out_valid & out_ready. Both imply ~freeze & ~flush.
- out_valid = main_valid & ~freeze & ~flush (combinational mask); out_pc/out_data always driven from the main entry.
- Flush: next state is empty; main and skid PC go to 0, payload to BUBBLE_DATA; the input offered that cycle is dropped; in_ready=0 that cycle. A flush asserted together with freeze still flushes.
- Freeze: in_ready=0, out_valid=0, all entries and occupancy held; freeze_cnt increments (saturates at all-ones, no wrap). freeze_cnt is cleared only by rst, not by flush.
- SKID=1: state machine EMPTY/ONE/TWO (occupancy 0/1/2). in_ready = (state!=TWO) & ~freeze & ~flush, with no dependence on out_ready.
  - EMPTY: accept -> ONE, input loads the main entry.
  - ONE: accept&~emit -> TWO, input loads the skid entry. accept&emit -> ONE, input loads main. ~accept&emit -> EMPTY, main cleared to bubble. Otherwise hold.
  - TWO: emit -> ONE, skid moves to main and skid is cleared to bubble. Otherwise hold. No accept is possible in TWO.
- SKID=0: single entry. in_ready = (~main_valid | out_ready) & ~freeze & ~flush (combinational out_ready->in_ready path, documented for timing). Simultaneous accept and emit replaces the entry, giving full throughput.
- Latency: an accepted entry appears on out_* the next cycle, giving 1 cycle minimum. Order is strictly FIFO and no entry is duplicated or lost except by flush.
- Throughput: 1 entry/cycle sustained in both modes when out_ready=1.
- Empty stage: out_pc=0, out_data=BUBBLE_DATA.

Decomposition:
- Shared pipeline package: default PC_W/DATA_W, NOP/bubble encoding constant, the stage-state enum (EMPTY, ONE, TWO).
- One natural sub-module: sat_counter (CNT_W, inc, clear) for freeze_cnt, reusable by other perf counters.
- Entry storage stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_pc=0, out_data=BUBBLE_DATA, occupancy=0, freeze_cnt=0; first accept after release appears on out_* exactly 1 cycle later.
- Streaming with SKID=1 and out_ready=1: PCs 0x00,0x04,0x08,0x0C on consecutive cycles -> out_pc 0x00..0x0C on consecutive cycles, occupancy stays 1, no gaps.
- Backpressure with SKID=1: out_ready=0 while 3 entries are offered -> first two accepted (occupancy=2, in_ready=0), third held upstream. Then out_ready=1 -> outputs in order 0x00,0x04,0x08, and in_ready returns 1 one cycle after the first emit.
- Freeze: occupancy=1 with PC 0x40, freeze=1 for 5 cycles with out_ready=1, in_valid=1 -> out_valid=0, in_ready=0, PC 0x40 retained, freeze_cnt=5. With CNT_W=4 and 20 freeze cycles -> freeze_cnt=15 (saturated).
- Flush: occupancy=2 plus in_valid=1, flush=1 for one cycle with freeze=1 -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_DATA; none of the three entries ever appears on the output.
- SKID=0: out_ready toggling 1,0,1 with in_valid=1 -> in_ready follows out_ready in the same cycle while full; accepted PCs exit in order with no duplication.
